game_ctrl_fsm: RTL

Parametrised game-control block that owns the game-over (break) flag and feeds it to the Dino, Huddle and Score sub-blocks. It derives a one-cycle frame tick from the VGA counters and checks Dino-vs-obstacle collisions on up to NUM_OBS obstacle channels once per frame. It sequences IDLE/RUN/HIT/OVER on the space-key flag, and ramps a saturating speed level as frames elapse.

---
 rtl/game_ctrl_fsm.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/game_ctrl_fsm.sv
// Game-control block: owns the game-over flag, derives a per-frame tick from the
// VGA vertical counter, checks Dino/obstacle collisions and ramps the speed level.
module game_ctrl_fsm #(
  parameter int unsigned NUM_OBS          = 2,
  parameter int unsigned COORD_W          = 12,
  parameter int unsigned SPEED_W          = 3,
  parameter int unsigned FRAMES_PER_LEVEL = 600,
  parameter int unsigned HIT_HOLD_FRAMES  = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [10:0]                hor_reg,
  input  logic [9:0]                 ver_reg,
  input  logic                       Spaceflag,
  input  logic [COORD_W-1:0]         DinoPosHorFrom,
  input  logic [COORD_W-1:0]         DinoPosHorTo,
  input  logic [COORD_W-1:0]         DinoPosVerFrom,
  input  logic [COORD_W-1:0]         DinoPosVerTo,
  input  logic [NUM_OBS*COORD_W-1:0] obsHorFrom,
  input  logic [NUM_OBS*COORD_W-1:0] obsHorTo,
  input  logic [NUM_OBS*COORD_W-1:0] obsVerFrom,
  input  logic [NUM_OBS*COORD_W-1:0] obsVerTo,
  input  logic [NUM_OBS-1:0]         obs_valid,
  output logic                       breakGameFlag,
  output logic                       run_en,
  output logic                       restart,
  output logic                       frame_tick,
  output logic [NUM_OBS-1:0]         hit_mask,
  output logic [SPEED_W-1:0]         speed_level,
  output logic [1:0]                 state
);

  localparam int unsigned LVL_W  = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1;
  localparam int unsigned HOLD_W = $clog2(HIT_HOLD_FRAMES + 1);
  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(FRAMES_PER_LEVEL - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HIT_HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t               r_state, w_next;
  logic [9:0]           r_ver_q;
  logic                 r_frame_tick;
  logic                 r_space_q;
  logic [LVL_W-1:0]     r_lvl;
  logic [HOLD_W-1:0]    r_hold;
  logic [SPEED_W-1:0]   r_speed;
  logic [NUM_OBS-1:0]   r_hit_mask;
  logic                 r_break, r_run_en, r_restart;
  logic                 w_break_nx, w_run_nx, w_restart_nx;
  logic                 w_space_rise, w_any_hit;
  logic [NUM_OBS-1:0]   w_hit;
  logic                 w_unused_hor;

  // hor_reg stays on the port list only for bus compatibility
  assign w_unused_hor = ^hor_reg;
  assign w_space_rise = Spaceflag & ~r_space_q;
  assign w_any_hit    = |w_hit;

  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NUM_OBS; i++) begin
      w_hit[i] = obs_valid[i]
               & (DinoPosHorFrom <= obsHorTo[i*COORD_W +: COORD_W])
               & (obsHorFrom[i*COORD_W +: COORD_W] <= DinoPosHorTo)
               & (DinoPosVerFrom <= obsVerTo[i*COORD_W +: COORD_W])
               & (obsVerFrom[i*COORD_W +: COORD_W] <= DinoPosVerTo);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_break   <= 1'b1;
      r_run_en  <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_break   <= w_break_nx;
      r_run_en  <= w_run_nx;
      r_restart <= w_restart_nx;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_space_rise) w_next = RUN;
      RUN:  if (r_frame_tick && w_any_hit) w_next = HIT;
      HIT:  if (r_frame_tick && (r_hold == HOLD_LAST)) w_next = OVER;
      OVER: if (w_space_rise) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with r_state
  always_comb begin
    w_break_nx   = (w_next != RUN);
    w_run_nx     = (w_next == RUN);
    w_restart_nx = (r_state == OVER) && w_space_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ver_q      <= '0;
      r_frame_tick <= 1'b0;
      r_space_q    <= 1'b1;
    end else begin
      r_ver_q      <= ver_reg;
      r_frame_tick <= (ver_reg == '0) && (r_ver_q != '0);
      r_space_q    <= Spaceflag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl      <= '0;
      r_speed    <= '0;
      r_hit_mask <= '0;
      r_hold     <= '0;
    end else begin
      if (w_restart_nx) begin
        r_lvl      <= '0;
        r_speed    <= '0;
        r_hit_mask <= '0;
      end else if ((r_state == RUN) && r_frame_tick) begin
        if (w_any_hit) begin
          r_hit_mask <= w_hit;
        end else if (r_lvl == LVL_LAST) begin
          r_lvl <= '0;
          if (r_speed != '1) r_speed <= r_speed + 1'b1;
        end else begin
          r_lvl <= r_lvl + 1'b1;
        end
      end
      if (r_state != HIT)    r_hold <= '0;
      else if (r_frame_tick) r_hold <= r_hold + 1'b1;
    end
  end

  assign breakGameFlag = r_break;
  assign run_en        = r_run_en;
  assign restart       = r_restart;
  assign frame_tick    = r_frame_tick;
  assign hit_mask      = r_hit_mask;
  assign speed_level   = r_speed;
  assign state         = r_state;

endmodule
